if_fetch_buf: RTL and testbench
===============================

// Module: if_fetch_buf
// PURPOSE
//  Instruction-fetch stage directly downstream of the PC register.
//  - Takes fetch addresses from the PC stage, issues them on the instruction
//    bus, and buffers returned words in a small in-order FIFO.
//  - Presents {instruction, address} to the IF/ID stage with a valid/ready
//    handshake.
//  - On a jump, flushes buffered words and discards in-flight responses.
// PARAMETERS
//  DEPTH   2   buffer entries; also the cap on (outstanding + buffered), >=2
//  ADDR_W  32  address width
//  DATA_W  32  instruction width
//  NOP     32'h00000013  value driven on inst_o when buffer empty (addi x0,x0,0)
// PORTS
//  clk            in   1       clock, rising edge
//  rst_n          in   1       reset, asynchronous, active-low
//  pc_i           in   ADDR_W  fetch address from PC stage
//  pc_valid_i     in   1       pc_i valid
//  pc_ready_o     out  1       pc_i consumed this cycle (PC may advance)
//  flush_i        in   1       jump taken (ctrl JumpEnable), flush pipeline
//  ibus_req_o     out  1       bus request
//  ibus_addr_o    out  ADDR_W  bus address
//  ibus_gnt_i     in   1       bus grant (request accepted)
//  ibus_rvalid_i  in   1       read data valid (in order, >=1 cycle after gnt)
//  ibus_rdata_i   in   DATA_W  read data
//  inst_valid_o   out  1       instruction available to IF/ID
//  inst_o         out  DATA_W  instruction
//  inst_addr_o    out  ADDR_W  address of inst_o
//  inst_misalign_o out 1       misaligned-fetch flag (see CONFIGURATION)
//  inst_ready_i   in   1       IF/ID accepts instruction
// BEHAVIOUR
//  - State: buffer (count 0..DEPTH), outstanding counter out_cnt, discard
//    counter drop_cnt, in-flight address FIFO (DEPTH deep).
//  - Reset: all counters 0; inst_valid_o=0, inst_o=NOP, inst_addr_o=0,
//    inst_misalign_o=0, ibus_req_o=0, pc_ready_o=0.
//  - Issue: ibus_req_o = pc_valid_i & !flush_i & (out_cnt+count < DEPTH);
//    ibus_addr_o = pc_i; pc_ready_o = ibus_req_o & ibus_gnt_i.
//    On grant, push pc_i to the address FIFO; out_cnt+1.
//  - Response: on ibus_rvalid_i, out_cnt-1 and pop the address FIFO.
//    - drop_cnt>0: drop_cnt-1, data discarded.
//    - Otherwise push {addr, rdata} into the buffer.
//    - rvalid while out_cnt==0 is ignored (no counter change).
//  - Latency: rvalid at cycle N -> inst_valid_o=1 at N+1 (registered).
//    No combinational path from ibus_rdata_i to inst_o.
//  - Output: inst_valid_o = (count!=0); head entry is popped when
//    inst_valid_o & inst_ready_i. Push and pop in the same cycle leave count
//    unchanged. The credit rule guarantees no overflow; count never exceeds DEPTH.
//  - Flush (flush_i=1):
//    - No request that cycle.
//    - Buffer emptied at the next edge.
//    - drop_cnt <= out_cnt - (ibus_rvalid_i & out_cnt!=0); a response arriving
//      in the flush cycle is itself dropped.
//    - A pop on the flush cycle has no effect beyond the flush.
//    - The first post-flush request may issue the cycle after flush_i falls,
//      even with drop_cnt>0, provided credit allows.
//  - Reset asserted mid-operation clears all state immediately; responses to
//    pre-reset requests are the bus's responsibility.
//  - Counters are sized $clog2(DEPTH+1) bits; no wrap-around by construction.
// CONFIGURATION
//  IF_MISALIGN_TRAP_EN defined:
//  - A valid pc_i with pc_i[1:0]!=0 is not sent on the bus.
//  - When out_cnt==0 and count<DEPTH, it is accepted (pc_ready_o=1) and pushed
//    directly as {NOP, pc_i, misalign=1}; otherwise it stalls.
//  - inst_misalign_o reflects the head entry's flag.
//  IF_MISALIGN_TRAP_EN undefined:
//  - ibus_addr_o[1:0] forced to 2'b00; inst_addr_o carries the aligned address.
//  - inst_misalign_o tied 0; no misalign storage.
// TESTING
//  - Stream: bus gnt=1 always, rvalid 1 cycle after gnt, ready=1, pc 0,4,8..
//    -> inst_valid_o continuous from cycle 3; inst_addr_o 0,4,8 in order.
//  - Backpressure: inst_ready_i=0 -> after 2 grants ibus_req_o=0 and
//    pc_ready_o=0. Ready=1 -> words 0x00100093,0x00200113 exit in order.
//  - Flush with 2 outstanding, bus returns 0xDEAD0001/0xDEAD0002 after flush
//    -> both dropped. Jump target 0x80 fetched; first inst_addr_o=0x80.
//  - Flush in the same cycle as rvalid with out_cnt=1 -> drop_cnt=0;
//    the word never appears.
//  - Reset mid-stream with count=2 -> inst_valid_o=0, inst_o=0x00000013
//    immediately, all counters 0.
//  - With IF_MISALIGN_TRAP_EN: pc_i=0x102 -> no ibus_req_o;
//    inst_misalign_o=1, inst_addr_o=0x102, inst_o=0x00000013.

Source files
------------

// File: rtl/if_fetch_buf_if.sv
// if_fetch_buf_if: PC-stage, instruction-bus and IF/ID-stage signals of the
// instruction-fetch buffer, bundled for one module port.
// The master modport is the fetch buffer; slave is the surrounding pipeline/bus.
interface if_fetch_buf_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    // PC stage
    logic [ADDR_W-1:0] pc_i;
    logic              pc_valid_i;
    logic              pc_ready_o;
    logic              flush_i;
    // Instruction bus
    logic              ibus_req_o;
    logic [ADDR_W-1:0] ibus_addr_o;
    logic              ibus_gnt_i;
    logic              ibus_rvalid_i;
    logic [DATA_W-1:0] ibus_rdata_i;
    // IF/ID stage
    logic              inst_valid_o;
    logic [DATA_W-1:0] inst_o;
    logic [ADDR_W-1:0] inst_addr_o;
    logic              inst_misalign_o;
    logic              inst_ready_i;

    modport master (
        input  pc_i, pc_valid_i, flush_i,
        input  ibus_gnt_i, ibus_rvalid_i, ibus_rdata_i,
        input  inst_ready_i,
        output pc_ready_o,
        output ibus_req_o, ibus_addr_o,
        output inst_valid_o, inst_o, inst_addr_o, inst_misalign_o
    );

    modport slave (
        output pc_i, pc_valid_i, flush_i,
        output ibus_gnt_i, ibus_rvalid_i, ibus_rdata_i,
        output inst_ready_i,
        input  pc_ready_o,
        input  ibus_req_o, ibus_addr_o,
        input  inst_valid_o, inst_o, inst_addr_o, inst_misalign_o
    );
endinterface

// File: rtl/if_fetch_buf.sv
// if_fetch_buf: instruction-fetch stage between the PC register and IF/ID.
// Issues fetch addresses on the instruction bus under a credit limit of DEPTH
// (in-flight + buffered), keeps returned words in an in-order FIFO and hands
// {instruction, address} to IF/ID. A flush empties the FIFO and marks every
// in-flight response for discard.
// Optional feature macro: IF_MISALIGN_TRAP_EN -- misaligned PCs are not sent
// on the bus but turned into a NOP entry carrying a misalign flag. Without it
// the low two address bits are forced to zero and no flag is stored.
module if_fetch_buf #(
    parameter int                DEPTH  = 2,
    parameter int                ADDR_W = 32,
    parameter int                DATA_W = 32,
    parameter logic [DATA_W-1:0] NOP    = DATA_W'(32'h00000013)
) (
    input logic            clk,
    input logic            rst_n,
    if_fetch_buf_if.master fb
);
    localparam int              CW       = $clog2(DEPTH + 1);
    localparam int              PW       = $clog2(DEPTH);
    localparam logic [CW:0]     DEPTH_X  = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0]   DEPTH_C  = CW'(DEPTH);
    localparam logic [PW-1:0]   LAST_PTR = PW'(DEPTH - 1);

    // Control state
    logic [CW-1:0]     count;       // words held in the output buffer
    logic [CW-1:0]     out_cnt;     // granted requests still awaiting rvalid
    logic [CW-1:0]     drop_cnt;    // leading responses to discard after a flush
    logic [PW-1:0]     buf_rd;
    logic [PW-1:0]     buf_wr;
    logic [PW-1:0]     af_rd;
    logic [PW-1:0]     af_wr;

    // Data storage (not reset; qualified by the counters)
    logic [DATA_W-1:0] buf_data [DEPTH];
    logic [ADDR_W-1:0] buf_addr [DEPTH];
    logic [ADDR_W-1:0] af_addr  [DEPTH];

    // Per-cycle decisions
    logic              credit_ok;
    logic              issue_req;
    logic              issue;
    logic              pc_accept;
    logic              rsp_take;
    logic              rsp_keep;
    logic              buf_push;
    logic              buf_pop;
    logic [ADDR_W-1:0] fetch_addr;
    logic [DATA_W-1:0] push_data;
    logic [ADDR_W-1:0] push_addr;

`ifdef IF_MISALIGN_TRAP_EN
    logic              buf_mis [DEPTH];
    logic              pc_misaligned;
    logic              mis_accept;
    logic              push_mis;
`endif

    // Circular pointer advance; DEPTH need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    // Issue side: credit check, bus request and the PC-stage handshake.
    always_comb begin
        credit_ok = ({1'b0, out_cnt} + {1'b0, count}) < DEPTH_X;
`ifdef IF_MISALIGN_TRAP_EN
        pc_misaligned = (fb.pc_i[1:0] != 2'b00);
        fetch_addr    = fb.pc_i;
        issue_req     = rst_n & fb.pc_valid_i & ~fb.flush_i & credit_ok & ~pc_misaligned;
        // A misaligned PC only becomes an entry once nothing is in flight, so it
        // cannot overtake older fetches and never collides with a bus response.
        mis_accept    = rst_n & fb.pc_valid_i & ~fb.flush_i & pc_misaligned
                        & (out_cnt == '0) & (count < DEPTH_C);
        issue         = issue_req & fb.ibus_gnt_i;
        pc_accept     = issue | mis_accept;
`else
        fetch_addr    = fb.pc_i & ~ADDR_W'(3);
        issue_req     = rst_n & fb.pc_valid_i & ~fb.flush_i & credit_ok;
        issue         = issue_req & fb.ibus_gnt_i;
        pc_accept     = issue;
`endif
    end

    // Response side and output-buffer push/pop selection.
    always_comb begin
        // rvalid with nothing outstanding is a stray beat and is ignored.
        rsp_take  = fb.ibus_rvalid_i & (out_cnt != '0);
        // A response arriving in the flush cycle is discarded with the buffer.
        rsp_keep  = rsp_take & (drop_cnt == '0) & ~fb.flush_i;
        buf_pop   = (count != '0) & fb.inst_ready_i & ~fb.flush_i;
        buf_push  = rsp_keep;
        push_data = fb.ibus_rdata_i;
        push_addr = af_addr[af_rd];
`ifdef IF_MISALIGN_TRAP_EN
        push_mis  = 1'b0;
        if (mis_accept) begin
            buf_push  = 1'b1;
            push_data = NOP;
            push_addr = fb.pc_i;
            push_mis  = 1'b1;
        end
`endif
    end

    // Counters and pointers; cleared asynchronously, flush restarts the buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= '0;
            out_cnt  <= '0;
            drop_cnt <= '0;
            buf_rd   <= '0;
            buf_wr   <= '0;
            af_rd    <= '0;
            af_wr    <= '0;
        end else begin
            out_cnt <= out_cnt + CW'(issue) - CW'(rsp_take);
            if (issue) begin
                af_wr <= ptr_inc(af_wr);
            end
            if (rsp_take) begin
                af_rd <= ptr_inc(af_rd);
            end

            // Everything still outstanding after this cycle belongs to the old path.
            if (fb.flush_i) begin
                drop_cnt <= out_cnt - CW'(rsp_take);
            end else if (rsp_take && (drop_cnt != '0)) begin
                drop_cnt <= drop_cnt - CW'(1);
            end

            if (fb.flush_i) begin
                count  <= '0;
                buf_rd <= '0;
                buf_wr <= '0;
            end else begin
                count <= count + CW'(buf_push) - CW'(buf_pop);
                if (buf_push) begin
                    buf_wr <= ptr_inc(buf_wr);
                end
                if (buf_pop) begin
                    buf_rd <= ptr_inc(buf_rd);
                end
            end
        end
    end

    // Address FIFO and output-buffer storage writes.
    always_ff @(posedge clk) begin
        if (issue) begin
            af_addr[af_wr] <= fetch_addr;
        end
        if (buf_push) begin
            buf_data[buf_wr] <= push_data;
            buf_addr[buf_wr] <= push_addr;
`ifdef IF_MISALIGN_TRAP_EN
            buf_mis[buf_wr]  <= push_mis;
`endif
        end
    end

    // Outputs: the buffer head is presented straight from registers, so returned
    // data reaches inst_o one cycle after rvalid with no combinational path.
    assign fb.pc_ready_o   = pc_accept;
    assign fb.ibus_req_o   = issue_req;
    assign fb.ibus_addr_o  = fetch_addr;
    assign fb.inst_valid_o = (count != '0);
    assign fb.inst_o       = (count != '0) ? buf_data[buf_rd] : NOP;
    assign fb.inst_addr_o  = (count != '0) ? buf_addr[buf_rd] : '0;
`ifdef IF_MISALIGN_TRAP_EN
    assign fb.inst_misalign_o = (count != '0) & buf_mis[buf_rd];
`else
    assign fb.inst_misalign_o = 1'b0;
`endif
endmodule

// File: tb/tb_if_fetch_buf.sv
// tb_if_fetch_buf: randomized and directed bench for if_fetch_buf.
// Reference model: queue of in-flight fetches (each tagged drop/keep) and a
// queue of buffered instructions; bus model: queue of granted beats.
`timescale 1ns/1ps
module tb_if_fetch_buf;
    localparam int          DEPTH = 2;
    localparam logic [31:0] NOP   = 32'h00000013;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    if_fetch_buf_if #(.ADDR_W(32), .DATA_W(32)) fb ();

    if_fetch_buf #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32), .NOP(NOP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .fb    (fb)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct { logic [31:0] addr; bit drop; } fl_t;
    typedef struct { logic [31:0] data; logic [31:0] addr; bit mis; } be_t;
    typedef struct { logic [31:0] data; int stamp; } bp_t;

    fl_t         m_fl[$];
    be_t         m_buf[$];
    bp_t         bus_q[$];
    logic [31:0] data_ovr[$];

    bit          exp_req, exp_pc_ready, exp_valid, exp_mis, mis_acc;
    logic [31:0] exp_bus_addr, exp_inst, exp_iaddr;

    function automatic void model_clear();
        m_fl.delete();
        m_buf.delete();
        bus_q.delete();
        data_ovr.delete();
    endfunction

    // Expected outputs for the current inputs and model state.
    function automatic void model_eval();
        bit mis;
`ifdef IF_MISALIGN_TRAP_EN
        mis          = (fb.pc_i[1:0] != 2'b00);
        exp_bus_addr = fb.pc_i;
`else
        mis          = 1'b0;
        exp_bus_addr = {fb.pc_i[31:2], 2'b00};
`endif
        exp_req      = rst_n && fb.pc_valid_i && !fb.flush_i && !mis
                       && ((m_fl.size() + m_buf.size()) < DEPTH);
        mis_acc      = rst_n && fb.pc_valid_i && !fb.flush_i && mis
                       && (m_fl.size() == 0) && (m_buf.size() < DEPTH);
        exp_pc_ready = (exp_req && fb.ibus_gnt_i) || mis_acc;
        exp_valid    = (m_buf.size() != 0);
        if (exp_valid) begin
            exp_inst  = m_buf[0].data;
            exp_iaddr = m_buf[0].addr;
            exp_mis   = m_buf[0].mis;
        end else begin
            exp_inst  = NOP;
            exp_iaddr = 32'h0;
            exp_mis   = 1'b0;
        end
    endfunction

    // Apply inputs just after the falling edge, then evaluate the model.
    task automatic drive(input bit pv, input logic [31:0] pc, input bit fl,
                         input bit rdy, input int gp, input int rp);
        fb.pc_valid_i    = pv;
        fb.pc_i          = pc;
        fb.flush_i       = fl;
        fb.inst_ready_i  = rdy;
        fb.ibus_gnt_i    = (int'($urandom_range(99)) < gp);
        fb.ibus_rvalid_i = 1'b0;
        fb.ibus_rdata_i  = $urandom;
        if (bus_q.size() != 0) begin
            if (bus_q[0].stamp < cyc && int'($urandom_range(99)) < rp) begin
                fb.ibus_rvalid_i = 1'b1;
                fb.ibus_rdata_i  = bus_q[0].data;
            end
        end
        #1;
        model_eval();
    endtask

    // Commit the model for this cycle and advance to the next falling edge.
    task automatic tick();
        fl_t         e;
        bit          rsp;
        logic [31:0] d;
        e = '{addr: 32'h0, drop: 1'b0};
        if (rst_n) begin
            rsp = fb.ibus_rvalid_i && (m_fl.size() != 0);
            if (rsp) e = m_fl.pop_front();
            if (fb.flush_i) begin
                foreach (m_fl[i]) m_fl[i].drop = 1'b1;
                m_buf.delete();
            end else begin
                if (exp_valid && fb.inst_ready_i) void'(m_buf.pop_front());
                if (rsp && !e.drop) m_buf.push_back('{fb.ibus_rdata_i, e.addr, 1'b0});
                if (mis_acc) m_buf.push_back('{NOP, fb.pc_i, 1'b1});
            end
            if (exp_req && fb.ibus_gnt_i) m_fl.push_back('{exp_bus_addr, 1'b0});
            if (fb.ibus_rvalid_i && bus_q.size() != 0) void'(bus_q.pop_front());
            if (exp_req && fb.ibus_gnt_i) begin
                if (data_ovr.size() != 0) d = data_ovr.pop_front();
                else d = $urandom;
                bus_q.push_back('{d, cyc});
            end
        end
        cyc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        drive(0, 32'h0, 0, 0, 0, 0);
        rst_n = 1'b0;
        model_clear();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #1;
        rst_n = 1'b0;
        drive(1, 32'h10, 0, 1, 100, 100);
        checks++; if (fb.inst_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", fb.inst_valid_o); end
        checks++; if (fb.inst_o !== NOP) begin errors++; $display("FAIL reset_inst: got %h want %h", fb.inst_o, NOP); end
        checks++; if (fb.inst_addr_o !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", fb.inst_addr_o); end
        checks++; if (fb.inst_misalign_o !== 1'b0) begin errors++; $display("FAIL reset_mis: got %b want 0", fb.inst_misalign_o); end
        checks++; if (fb.ibus_req_o !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", fb.ibus_req_o); end
        checks++; if (fb.pc_ready_o !== 1'b0) begin errors++; $display("FAIL reset_pc_ready: got %b want 0", fb.pc_ready_o); end
        model_clear();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_stream();
        logic [31:0] pc, next_exp;
        int          got;
        apply_reset();
        pc = 32'h0; next_exp = 32'h0; got = 0;
        for (int c = 0; c < 24; c++) begin
            drive(1, pc, 0, 1, 100, 100);
            if (c == 1 || c == 2) begin
                checks++;
                if (fb.inst_valid_o !== (c == 2)) begin errors++; $display("FAIL stream_latency c%0d: got %b want %b", c, fb.inst_valid_o, (c == 2)); end
            end
            checks++; if (fb.ibus_req_o !== exp_req) begin errors++; $display("FAIL stream_req c%0d: got %b want %b", c, fb.ibus_req_o, exp_req); end
            checks++; if (fb.inst_valid_o !== exp_valid) begin errors++; $display("FAIL stream_valid c%0d: got %b want %b", c, fb.inst_valid_o, exp_valid); end
            if (exp_valid) begin
                checks++;
                if (fb.inst_addr_o !== next_exp) begin errors++; $display("FAIL stream_order: got %h want %h", fb.inst_addr_o, next_exp); end
                next_exp += 32'd4;
                got++;
            end
            if (exp_pc_ready) pc += 32'd4;
            tick();
        end
        checks++; if (got < 8) begin errors++; $display("FAIL stream_count: got %0d want >=8", got); end
    endtask

    task automatic test_backpressure();
        logic [31:0] pc;
        logic [31:0] want[2];
        int          idx;
        apply_reset();
        want[0] = 32'h00100093; want[1] = 32'h00200113;
        data_ovr.push_back(want[0]);
        data_ovr.push_back(want[1]);
        pc = 32'h100;
        for (int c = 0; c < 6; c++) begin
            drive(1, pc, 0, 0, 100, 100);
            checks++; if (fb.ibus_req_o !== exp_req) begin errors++; $display("FAIL bp_req c%0d: got %b want %b", c, fb.ibus_req_o, exp_req); end
            if (c == 5) begin
                checks++; if (fb.ibus_req_o !== 1'b0) begin errors++; $display("FAIL bp_stall_req: got %b want 0", fb.ibus_req_o); end
                checks++; if (fb.pc_ready_o !== 1'b0) begin errors++; $display("FAIL bp_stall_pc_ready: got %b want 0", fb.pc_ready_o); end
            end
            if (exp_pc_ready) pc += 32'd4;
            tick();
        end
        idx = 0;
        for (int c = 0; c < 6 && idx < 2; c++) begin
            drive(0, pc, 0, 1, 0, 100);
            if (fb.inst_valid_o === 1'b1) begin
                checks++;
                if (fb.inst_o !== want[idx]) begin errors++; $display("FAIL bp_word%0d: got %h want %h", idx, fb.inst_o, want[idx]); end
                idx++;
            end
            tick();
        end
        checks++; if (idx != 2) begin errors++; $display("FAIL bp_drain: got %0d words want 2", idx); end
    endtask

    task automatic test_flush();
        logic [31:0] pc;
        bit          seen;
        apply_reset();
        data_ovr.push_back(32'hDEAD0001);
        data_ovr.push_back(32'hDEAD0002);
        pc = 32'h0;
        for (int c = 0; c < 2; c++) begin
            drive(1, pc, 0, 1, 100, 0);
            if (exp_pc_ready) pc += 32'd4;
            tick();
        end
        drive(1, 32'h80, 1, 1, 100, 0);
        checks++; if (fb.ibus_req_o !== 1'b0) begin errors++; $display("FAIL flush_req: got %b want 0", fb.ibus_req_o); end
        tick();
        pc = 32'h80; seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            drive(1, pc, 0, 1, 100, 100);
            checks++; if (fb.inst_valid_o !== exp_valid) begin errors++; $display("FAIL flush_valid c%0d: got %b want %b", c, fb.inst_valid_o, exp_valid); end
            if (fb.inst_valid_o === 1'b1) begin
                seen = 1;
                checks++; if (fb.inst_addr_o !== 32'h80) begin errors++; $display("FAIL flush_target: got %h want 00000080", fb.inst_addr_o); end
                checks++; if (fb.inst_o !== exp_inst) begin errors++; $display("FAIL flush_data: got %h want %h", fb.inst_o, exp_inst); end
            end
            if (exp_pc_ready) pc += 32'd4;
            tick();
        end
        checks++; if (!seen) begin errors++; $display("FAIL flush_timeout: got no instruction want addr 00000080"); end
    endtask

    task automatic test_flush_rvalid();
        bit seen;
        apply_reset();
        data_ovr.push_back(32'hBEEF0040);
        drive(1, 32'h40, 0, 1, 100, 0);
        tick();
        drive(0, 32'h0, 1, 1, 0, 100);
        checks++; if (fb.ibus_rvalid_i !== 1'b1) begin errors++; $display("FAIL fr_setup: got rvalid %b want 1", fb.ibus_rvalid_i); end
        tick();
        for (int c = 0; c < 4; c++) begin
            drive(0, 32'h0, 0, 1, 0, 100);
            if (c == 0) begin
                // stray beat with nothing outstanding
                fb.ibus_rvalid_i = 1'b1;
                fb.ibus_rdata_i  = 32'h0BAD0BAD;
            end
            checks++; if (fb.inst_valid_o !== 1'b0) begin errors++; $display("FAIL fr_dropped c%0d: got %b want 0", c, fb.inst_valid_o); end
            tick();
        end
        seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            drive(1, 32'h44, 0, 1, 100, 100);
            if (fb.inst_valid_o === 1'b1) begin
                seen = 1;
                checks++; if (fb.inst_addr_o !== 32'h44) begin errors++; $display("FAIL fr_next: got %h want 00000044", fb.inst_addr_o); end
            end
            tick();
        end
        checks++; if (!seen) begin errors++; $display("FAIL fr_timeout: got no instruction want addr 00000044"); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] pc;
        apply_reset();
        pc = 32'h200;
        for (int c = 0; c < 4; c++) begin
            drive(1, pc, 0, 0, 100, 100);
            if (exp_pc_ready) pc += 32'd4;
            tick();
        end
        drive(1, pc, 0, 0, 100, 100);
        checks++; if (fb.inst_valid_o !== 1'b1) begin errors++; $display("FAIL rm_full: got %b want 1", fb.inst_valid_o); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (fb.inst_valid_o !== 1'b0) begin errors++; $display("FAIL rm_valid: got %b want 0", fb.inst_valid_o); end
        checks++; if (fb.inst_o !== NOP) begin errors++; $display("FAIL rm_inst: got %h want %h", fb.inst_o, NOP); end
        checks++; if (fb.inst_addr_o !== 32'h0) begin errors++; $display("FAIL rm_addr: got %h want 0", fb.inst_addr_o); end
        checks++; if (fb.ibus_req_o !== 1'b0) begin errors++; $display("FAIL rm_req: got %b want 0", fb.ibus_req_o); end
        model_clear();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            drive(1, pc, 0, 1, 100, 100);
            if (c == 0) begin
                checks++; if (fb.ibus_req_o !== 1'b1) begin errors++; $display("FAIL rm_credit: got %b want 1", fb.ibus_req_o); end
            end
            checks++; if (fb.inst_valid_o !== exp_valid) begin errors++; $display("FAIL rm_post_valid c%0d: got %b want %b", c, fb.inst_valid_o, exp_valid); end
            if (exp_valid) begin
                checks++; if (fb.inst_addr_o !== exp_iaddr) begin errors++; $display("FAIL rm_post_addr: got %h want %h", fb.inst_addr_o, exp_iaddr); end
            end
            if (exp_pc_ready) pc += 32'd4;
            tick();
        end
    endtask

`ifdef IF_MISALIGN_TRAP_EN
    task automatic test_misalign();
        apply_reset();
        drive(1, 32'h102, 0, 0, 100, 100);
        checks++; if (fb.ibus_req_o !== 1'b0) begin errors++; $display("FAIL mis_req: got %b want 0", fb.ibus_req_o); end
        checks++; if (fb.pc_ready_o !== 1'b1) begin errors++; $display("FAIL mis_pc_ready: got %b want 1", fb.pc_ready_o); end
        tick();
        drive(0, 32'h0, 0, 0, 0, 0);
        checks++; if (fb.inst_valid_o !== 1'b1) begin errors++; $display("FAIL mis_valid: got %b want 1", fb.inst_valid_o); end
        checks++; if (fb.inst_misalign_o !== 1'b1) begin errors++; $display("FAIL mis_flag: got %b want 1", fb.inst_misalign_o); end
        checks++; if (fb.inst_addr_o !== 32'h102) begin errors++; $display("FAIL mis_addr: got %h want 00000102", fb.inst_addr_o); end
        checks++; if (fb.inst_o !== NOP) begin errors++; $display("FAIL mis_inst: got %h want %h", fb.inst_o, NOP); end
        tick();
    endtask
`endif

    task automatic test_random();
        logic [31:0] pc;
        bit          fl;
        apply_reset();
        pc = $urandom & 32'h0000_FFFC;
        for (int c = 0; c < 600; c++) begin
            fl = (int'($urandom_range(99)) < 6);
            drive(($urandom_range(3) != 0), pc, fl, (int'($urandom_range(99)) < 70), 70, 60);
            checks++; if (fb.ibus_req_o !== exp_req) begin errors++; $display("FAIL rnd_req c%0d: got %b want %b", c, fb.ibus_req_o, exp_req); end
            checks++; if (fb.pc_ready_o !== exp_pc_ready) begin errors++; $display("FAIL rnd_pc_ready c%0d: got %b want %b", c, fb.pc_ready_o, exp_pc_ready); end
            if (exp_req) begin
                checks++; if (fb.ibus_addr_o !== exp_bus_addr) begin errors++; $display("FAIL rnd_bus_addr c%0d: got %h want %h", c, fb.ibus_addr_o, exp_bus_addr); end
            end
            checks++; if (fb.inst_valid_o !== exp_valid) begin errors++; $display("FAIL rnd_valid c%0d: got %b want %b", c, fb.inst_valid_o, exp_valid); end
            checks++; if (fb.inst_o !== exp_inst) begin errors++; $display("FAIL rnd_inst c%0d: got %h want %h", c, fb.inst_o, exp_inst); end
            checks++; if (fb.inst_addr_o !== exp_iaddr) begin errors++; $display("FAIL rnd_addr c%0d: got %h want %h", c, fb.inst_addr_o, exp_iaddr); end
            checks++; if (fb.inst_misalign_o !== exp_mis) begin errors++; $display("FAIL rnd_mis c%0d: got %b want %b", c, fb.inst_misalign_o, exp_mis); end
            if (fl) begin
                pc = $urandom & 32'h0000_FFFC;
            end else if (exp_pc_ready) begin
                pc = (pc & 32'hFFFF_FFFC) + 32'd4;
            end
            if ($urandom_range(15) == 0) pc[1:0] = 2'($urandom_range(3));
            tick();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_flush_rvalid();
        test_reset_mid();
`ifdef IF_MISALIGN_TRAP_EN
        test_misalign();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
